neurona_serial: RTL
===================

Name: neurona_serial

Overview:
- Parametrised sequential neuron for the digit-recognition datapath.
- Takes N_INPUTS binary pixels and N_INPUTS signed weights, all flattened, plus a signed bias.
- Accumulates one weighted term per clock, then applies a selectable activation and saturates the result to OUT_WIDTH.
- Upstream control uses a start/busy/done handshake; it replaces the flat combinational neuron so that later layers can reuse one MAC per neuron.

Parameters:
- N_INPUTS, 49, number of pixel/weight pairs (7x7 image).
- W_WIDTH, 8, signed weight and bias width.
- ACC_WIDTH, 16, signed accumulator width. Elaboration error if ACC_WIDTH < W_WIDTH + clog2(N_INPUTS+1) + 1.
- OUT_WIDTH, 8, signed output width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  request; sampled only in IDLE.
- act_mode  in  2  activation select, captured at start: 0 identity, 1 ReLU, 2 step, 3 reserved (treated as identity).
- pixels  in  N_INPUTS  pixel i at bit i.
- weights  in  N_INPUTS*W_WIDTH  weight i at bits [i*W_WIDTH +: W_WIDTH], signed.
- bias  in  W_WIDTH  signed bias.
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse; out is valid.
- out  out  OUT_WIDTH  signed result; holds until the next done.

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; busy=0, done=0, out=0, acc=0, idx=0. Reset overrides everything, including mid-computation; any partial result is discarded and no done is produced.
- States:
  - IDLE: start=1 captures pixels, weights, bias and act_mode into internal registers; acc<=sign-extended bias; idx<=0; busy<=1; go to ACC. Inputs are don't-care after this capture edge.
  - ACC: each cycle, if pixel_r[idx]=1 then acc<=acc+sext(weight_r[idx]), otherwise acc holds. idx<=idx+1. When idx==N_INPUTS-1, go to ACT.
  - ACT: out<=activation(acc) saturated to OUT_WIDTH; done<=1; busy<=0; go to IDLE.
- Timing:
  - Latency: start sampled at edge 0; done and the new out are visible after edge N_INPUTS+1.
  - busy is high after edges 0..N_INPUTS and drops together with the rise of done.
- Activation:
  - Identity: clamp acc to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - ReLU: negative values give 0; positive values are clamped to the maximum.
  - Step: acc>0 gives 1; otherwise 0.
- Arithmetic: full-width signed accumulation with no wrap (guaranteed by the elaboration check). Saturation applies only at the output.
- Boundaries:
  - start while busy is ignored. No queueing.
  - start in the same cycle done=1 is accepted; the FSM is in IDLE then, so back-to-back operations run with 1 idle-free gap.
  - Pixels all zero give out = act(bias).
  - idx counter width is clog2(N_INPUTS); it never wraps because of the exit condition.
  - N_INPUTS=1 is legal: exactly 1 ACC cycle.

Decomposition:
- Package neurona_pkg holds:
  - ACT_IDENTITY/ACT_RELU/ACT_STEP localparams.
  - FSM state encoding (IDLE, ACC, ACT).
  - A clog2 function.
- Sub-module neurona_activation (combinational, parameters ACC_WIDTH/OUT_WIDTH): takes acc and mode, returns the saturated out. It is reused by later layers.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, start=0 -> busy=0, done=0, out=0 throughout. Then N_INPUTS=49, all pixels=1, all weights=+1, bias=0, identity -> done exactly 50 cycles after the start edge, out=49, busy high 50 cycles.
- Saturation: all pixels=1, weights=127, bias=127. Identity -> out=127. Weights=-128, bias=-128: identity -> out=-128, ReLU -> out=0, step -> out=0.
- Pixel masking: pixels alternate 1,0 (even bits=1), weight_i=i-24, bias=-3, identity -> sum over even i of (i-24) = 0, out=-3. Step with bias=+3 -> out=1.
- Mid-operation reset: start, then reset_n=0 at cycle 20 for 1 cycle -> busy=0, out=0, no done pulse. A new start after reset gives the correct result in 50 cycles.
- Handshake edges: start held high continuously with a fixed input vector -> operations repeat, done pulses every 51 cycles, and start during busy does not restart idx. Inputs changed 1 cycle after the start edge do not affect out.
- Parameter sweep: N_INPUTS=1, weight=-5, pixel=1, bias=2, ReLU -> done 2 cycles after start, out=0. Identity -> out=-3.

Source files
------------

// File: rtl/neurona_pkg.sv
// Shared definitions for the serial neuron and its activation stage.
package neurona_pkg;

  localparam logic [1:0] ACT_IDENTITY = 2'd0;
  localparam logic [1:0] ACT_RELU     = 2'd1;
  localparam logic [1:0] ACT_STEP     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_ACT  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/neurona_activation.sv
// Combinational activation with saturation of a wide signed accumulator.
module neurona_activation
  import neurona_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic        [1:0]           mode_i,
  output logic        [OUT_WIDTH-1:0] out_o
);

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(1 << (OUT_WIDTH-1)));

  logic signed [ACC_WIDTH-1:0] clamped;

  always_comb begin
    clamped = acc_i;
    if (acc_i > OUT_MAX)      clamped = OUT_MAX;
    else if (acc_i < OUT_MIN) clamped = OUT_MIN;
  end

  always_comb begin
    out_o = clamped[OUT_WIDTH-1:0];
    case (mode_i)
      ACT_RELU: if (acc_i < 0) out_o = '0;
      ACT_STEP: out_o = (acc_i > 0) ? OUT_WIDTH'(1) : '0;
      default:  out_o = clamped[OUT_WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/neurona_serial.sv
// Sequential neuron: one weighted pixel term per clock, then activation.
// state   | meaning
// IDLE    | waiting for start; out holds last result
// ACC     | adding weight[idx] when pixel[idx] is set
// ACT     | registering activated output and pulsing done
module neurona_serial
  import neurona_pkg::*;
#(
  parameter int N_INPUTS  = 49,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [1:0]                    act_mode,
  input  logic [N_INPUTS-1:0]           pixels,
  input  logic [N_INPUTS*W_WIDTH-1:0]   weights,
  input  logic [W_WIDTH-1:0]            bias,
  output logic                          busy,
  output logic                          done,
  output logic [OUT_WIDTH-1:0]          out
);

  localparam int IDX_W = (clog2(N_INPUTS) > 0) ? clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  if (ACC_WIDTH < W_WIDTH + clog2(N_INPUTS + 1) + 1) begin : g_acc_too_narrow
    $error("neurona_serial: ACC_WIDTH too small for N_INPUTS/W_WIDTH");
  end

  state_e                        state_q, state_d;
  logic [N_INPUTS-1:0]           pix_q, pix_d;
  logic [N_INPUTS*W_WIDTH-1:0]   wgt_q, wgt_d;
  logic [1:0]                    mode_q, mode_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic [OUT_WIDTH-1:0]          out_q, out_d;

  logic [W_WIDTH-1:0]            w_cur;
  logic signed [ACC_WIDTH-1:0]   w_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic [OUT_WIDTH-1:0]          act_out;

  assign w_cur    = wgt_q[idx_q*W_WIDTH +: W_WIDTH];
  assign w_ext    = {{(ACC_WIDTH-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
  assign bias_ext = {{(ACC_WIDTH-W_WIDTH){bias[W_WIDTH-1]}}, bias};

  neurona_activation #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_act (
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .out_o  (act_out)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    wgt_d   = wgt_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pix_d   = pixels;
          wgt_d   = weights;
          mode_d  = act_mode;
          acc_d   = bias_ext;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (pix_q[idx_q]) acc_d = acc_q + w_ext;
        // idx parks at zero on exit so it never wraps for power-of-two sizes
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_ACT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ACT: begin
        out_d   = act_out;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      wgt_q   <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wgt_q   <= wgt_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
